// File: rtl/sme_pkg.sv
// sme_pkg: shared sizes, length-field widths and scan FSM states for the string-match engine
package sme_pkg;

    localparam int STR_MAX = 32;
    localparam int PAT_MAX = 8;
    localparam int IW      = $clog2(STR_MAX);
    localparam int SLW     = $clog2(STR_MAX) + 1;
    localparam int PLW     = $clog2(PAT_MAX) + 1;

    typedef enum logic [1:0] {IDLE, REQ, DONE} state_t;

    // Last legal window start; only called when pat_len <= str_len, so the result fits IW bits
    function automatic logic [IW-1:0] last_idx(input logic [SLW-1:0] s, input logic [PLW-1:0] p);
        logic [SLW-1:0] d;
        d = s - SLW'(p);
        return d[IW-1:0];
    endfunction

endpackage

// File: rtl/sme_scan_ctrl.sv
// sme_scan_ctrl: steps the candidate start index and schedules one window compare per index
module sme_scan_ctrl
    import sme_pkg::*;
(
    input  logic           clk,
    input  logic           reset,
    input  logic           start,
    input  logic [SLW-1:0] str_len,
    input  logic [PLW-1:0] pat_len,
    output logic           cmp_req,
    output logic [IW-1:0]  cmp_idx,
    input  logic           cmp_ack,
    input  logic           cmp_hit,
    output logic           busy,
    output logic           valid,
    output logic           match,
    output logic [IW-1:0]  match_index
);

    state_t        state_q;
    logic [IW-1:0] last_q;

    // Scan FSM with registered outputs; valid is a one-cycle strobe raised on entry to DONE
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            last_q      <= '0;
            cmp_req     <= 1'b0;
            cmp_idx     <= '0;
            busy        <= 1'b0;
            valid       <= 1'b0;
            match       <= 1'b0;
            match_index <= '0;
        end else begin
            valid <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (start) begin
                        cmp_idx <= '0;
                        busy    <= 1'b1;
                        if (SLW'(pat_len) > str_len) begin
                            state_q     <= DONE;
                            valid       <= 1'b1;
                            match       <= 1'b0;
                            match_index <= '0;
                        end else begin
                            state_q <= REQ;
                            last_q  <= last_idx(str_len, pat_len);
                            cmp_req <= 1'b1;
                        end
                    end
                end
                REQ: begin
                    if (cmp_ack) begin
                        if (cmp_hit || cmp_idx == last_q) begin
                            state_q     <= DONE;
                            cmp_req     <= 1'b0;
                            valid       <= 1'b1;
                            match       <= cmp_hit;
                            match_index <= cmp_hit ? cmp_idx : '0;
                        end else begin
                            cmp_idx <= cmp_idx + 1'b1;
                        end
                    end
                end
                DONE: begin
                    state_q <= IDLE;
                    busy    <= 1'b0;
                end
                default: begin
                    state_q <= IDLE;
                    cmp_req <= 1'b0;
                    busy    <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sme_scan_ctrl.sv
// tb_sme_scan_ctrl: scoreboard bench with a behavioural window comparator
module tb_sme_scan_ctrl;
    import sme_pkg::*;

    logic           clk = 1'b0;
    logic           reset = 1'b0;
    logic           start = 1'b0;
    logic [SLW-1:0] str_len = '0;
    logic [PLW-1:0] pat_len = '0;
    logic           cmp_ack = 1'b0;
    logic           cmp_hit = 1'b0;
    logic           cmp_req, busy, valid, match;
    logic [IW-1:0]  cmp_idx, match_index;

    typedef struct {
        logic          m;
        logic [IW-1:0] i;
    } res_t;

    res_t sb[$];
    int   passed = 0;
    int   total = 0;
    int   hit_idx = -1;
    int   ack_dly = 0;
    int   exp_idx = 0;
    int   ack_cnt = 0;
    bit   stray = 1'b0;

    always #5 clk = ~clk;

    sme_scan_ctrl dut (
        .clk(clk), .reset(reset), .start(start), .str_len(str_len), .pat_len(pat_len),
        .cmp_req(cmp_req), .cmp_idx(cmp_idx), .cmp_ack(cmp_ack), .cmp_hit(cmp_hit),
        .busy(busy), .valid(valid), .match(match), .match_index(match_index)
    );

    // Comparator model: acks each window after ack_dly wait cycles, checks cmp_idx is held and stepped by one
    initial begin
        int cnt;
        cnt = 0;
        forever begin
            @(negedge clk);
            if (cmp_req === 1'b1) begin
                total++;
                if (cmp_idx !== exp_idx[IW-1:0])
                    $display("FAIL cmp_idx: got %0d want %0d", cmp_idx, exp_idx);
                else
                    passed++;
                if (cnt == ack_dly) begin
                    cmp_ack = 1'b1;
                    cmp_hit = (int'(cmp_idx) == hit_idx);
                    ack_cnt++;
                    exp_idx++;
                    cnt = 0;
                end else begin
                    cmp_ack = 1'b0;
                    cmp_hit = 1'b0;
                    cnt++;
                end
            end else begin
                cmp_ack = stray;
                cmp_hit = stray;
                cnt = 0;
            end
        end
    end

    // Result monitor: every valid strobe pops and compares one scoreboard entry
    initial begin
        res_t e;
        forever begin
            @(negedge clk);
            if (valid === 1'b1) begin
                total++;
                if (sb.size() == 0) begin
                    $display("FAIL unexpected_valid: got valid=1 match=%b idx=%0d want no valid", match, match_index);
                end else begin
                    e = sb.pop_front();
                    if (match !== e.m || match_index !== e.i)
                        $display("FAIL result: got match=%b idx=%0d want match=%b idx=%0d", match, match_index, e.m, e.i);
                    else
                        passed++;
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got no end of run want finish");
        $fatal(1, "watchdog");
    end

    task automatic run_scan(input string name, input int sl, input int pl, input int hit, input int dly, input bit mid_start);
        int   last, exp_acks, exp_lat, n;
        bit   seen;
        res_t e;
        assert (sl > 0 && pl > 0);
        last = sl - pl;
        e.m = (pl <= sl && hit >= 0 && hit <= last);
        e.i = e.m ? hit[IW-1:0] : '0;
        exp_acks = (pl > sl) ? 0 : (e.m ? hit + 1 : last + 1);
        exp_lat = exp_acks * (dly + 1) + 1;
        @(negedge clk);
        hit_idx = hit;
        ack_dly = dly;
        exp_idx = 0;
        ack_cnt = 0;
        str_len = sl[SLW-1:0];
        pat_len = pl[PLW-1:0];
        start = 1'b1;
        sb.push_back(e);
        seen = 1'b0;
        n = 0;
        for (int k = 1; k <= 400 && !seen; k++) begin
            @(negedge clk);
            n = k;
            start = mid_start && k == 5;
            if (mid_start && k == 5) begin
                str_len = 6'd5;
                pat_len = 4'd6;
            end
            if (valid === 1'b1) seen = 1'b1;
            else if (busy !== 1'b1) begin
                total++;
                $display("FAIL %s busy: got %b want 1 at cycle %0d", name, busy, k);
            end
        end
        total++;
        if (!seen) $display("FAIL %s timeout: got no valid want valid at cycle %0d", name, exp_lat);
        else if (n != exp_lat) $display("FAIL %s latency: got %0d want %0d", name, n, exp_lat);
        else passed++;
        total++;
        if (ack_cnt != exp_acks) $display("FAIL %s acks: got %0d want %0d", name, ack_cnt, exp_acks);
        else passed++;
        @(negedge clk);
        total++;
        if (valid !== 1'b0 || busy !== 1'b0 || match !== e.m || match_index !== e.i)
            $display("FAIL %s hold: got valid=%b busy=%b match=%b idx=%0d want 0 0 %b %0d", name, valid, busy, match, match_index, e.m, e.i);
        else
            passed++;
    endtask

    task automatic test_reset();
        #2 reset = 1'b1;
        #1;
        total++;
        if (cmp_req !== 1'b0 || cmp_idx !== '0 || busy !== 1'b0 || valid !== 1'b0 || match !== 1'b0 || match_index !== '0)
            $display("FAIL reset_state: got req=%b idx=%0d busy=%b valid=%b match=%b midx=%0d want all 0", cmp_req, cmp_idx, busy, valid, match, match_index);
        else
            passed++;
        repeat (2) @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic test_hit();
        run_scan("hit_zero_wait", 10, 3, 4, 0, 1'b0);
    endtask

    task automatic test_full_window_miss();
        run_scan("full_window_miss", 8, 8, -1, 0, 1'b0);
    endtask

    task automatic test_pat_too_long();
        run_scan("pat_too_long", 5, 6, -1, 0, 1'b0);
    endtask

    task automatic test_max_len_miss();
        run_scan("max_len_miss", 32, 1, -1, 0, 1'b0);
    endtask

    task automatic test_delayed_ack();
        run_scan("delayed_ack", 10, 3, 4, 3, 1'b1);
    endtask

    task automatic test_back_to_back();
        run_scan("b2b_a", 6, 2, 1, 0, 1'b0);
        run_scan("b2b_b", 4, 4, 0, 1, 1'b0);
        run_scan("b2b_c", 32, 8, 24, 0, 1'b0);
    endtask

    task automatic test_stray_ack();
        @(negedge clk);
        stray = 1'b1;
        repeat (3) begin
            @(negedge clk);
            total++;
            if (valid !== 1'b0 || busy !== 1'b0 || cmp_req !== 1'b0)
                $display("FAIL stray_ack: got valid=%b busy=%b req=%b want 0 0 0", valid, busy, cmp_req);
            else
                passed++;
        end
        stray = 1'b0;
    endtask

    task automatic test_reset_mid_scan();
        bit reached;
        @(negedge clk);
        hit_idx = -1;
        ack_dly = 0;
        exp_idx = 0;
        str_len = 6'd10;
        pat_len = 4'd3;
        start = 1'b1;
        reached = 1'b0;
        for (int k = 0; k < 20 && !reached; k++) begin
            @(negedge clk);
            start = 1'b0;
            if (cmp_req === 1'b1 && cmp_idx === 5'd2) reached = 1'b1;
        end
        total++;
        if (!reached) $display("FAIL reset_mid_reach: got no req at idx 2 want req at idx 2");
        else passed++;
        #2 reset = 1'b1;
        #1;
        total++;
        if (cmp_req !== 1'b0 || cmp_idx !== '0 || busy !== 1'b0 || valid !== 1'b0 || match !== 1'b0 || match_index !== '0)
            $display("FAIL reset_mid_abort: got req=%b idx=%0d busy=%b valid=%b match=%b midx=%0d want all 0", cmp_req, cmp_idx, busy, valid, match, match_index);
        else
            passed++;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        repeat (3) begin
            @(negedge clk);
            total++;
            if (valid !== 1'b0 || busy !== 1'b0)
                $display("FAIL reset_mid_quiet: got valid=%b busy=%b want 0 0", valid, busy);
            else
                passed++;
        end
        run_scan("after_reset", 10, 3, 4, 0, 1'b0);
    endtask

    initial begin
        test_reset();
        test_hit();
        test_full_window_miss();
        test_pat_too_long();
        test_max_len_miss();
        test_delayed_ack();
        test_back_to_back();
        test_stray_ack();
        test_reset_mid_scan();
        repeat (2) @(negedge clk);
        total++;
        if (sb.size() != 0) $display("FAIL scoreboard_drain: got %0d pending want 0", sb.size());
        else passed++;
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
